// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver.
//   DATA_WIDTH_DEF : default number of data bits per frame
//   PAR_ODD/EVEN   : encodings of the PAR_TYP input
//   state_t        : receiver FSM states
package uart_rx_pkg;

   localparam int   DATA_WIDTH_DEF = 8;
   localparam logic PAR_ODD        = 1'b0;
   localparam logic PAR_EVEN       = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_t;

endpackage

// File: rtl/uart_rx_par_chk.sv
// Combinational parity checker.
//   data     : received data word
//   par_typ  : PAR_ODD (expected bit = XNOR-reduce) or PAR_EVEN (XOR-reduce)
//   rx_bit   : parity bit taken from the line
//   mismatch : 1 when rx_bit differs from the expected parity bit
module uart_rx_par_chk
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   input  logic                  rx_bit,
   output logic                  mismatch
);

   logic expected;

   always_comb begin
      expected = (par_typ == PAR_EVEN) ? (^data) : (~^data);
      mismatch = rx_bit ^ expected;
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, one line bit per clk, LSB first, optional parity.
//   clk, reset             : clock and synchronous active-high reset
//   RX_IN                  : serial line (idles high)
//   PAR_EN, PAR_TYP        : parity enable / type, latched at the start bit
//   P_DATA                 : received word, held until the next frame completes
//   DATA_VALID             : one-cycle pulse in the cycle after the stop sample
//   PAR_ERR, STOP_ERR      : frame error flags, only nonzero with DATA_VALID
//   Busy                   : high whenever the FSM is not in IDLE
//   ERR_CNT                : saturating count of errored frames; present only
//                            when UART_RX_ERR_CNT_EN is defined
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  DATA_VALID,
   output logic                  PAR_ERR,
   output logic                  STOP_ERR,
   output logic                  Busy
`ifdef UART_RX_ERR_CNT_EN
   ,
   output logic [7:0]            ERR_CNT
`endif
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   state_t                  state_reg, state_next;
   logic [CNT_W-1:0]        bit_cnt_reg;
   logic [DATA_WIDTH-1:0]   shift_reg;
   logic                    par_en_reg;
   logic                    par_typ_reg;
   logic                    par_bit_reg;
   logic [DATA_WIDTH-1:0]   p_data_reg;
   logic                    data_valid_reg;
   logic                    par_err_reg;
   logic                    stop_err_reg;

   logic                    par_mismatch;
   logic                    par_err_next;
   logic                    stop_err_next;

   uart_rx_par_chk #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_par_chk (
      .data     (shift_reg),
      .par_typ  (par_typ_reg),
      .rx_bit   (par_bit_reg),
      .mismatch (par_mismatch)
   );

   // Error flags as they will be registered at the stop sample
   always_comb begin
      par_err_next  = par_en_reg & par_mismatch;
      stop_err_next = ~RX_IN;
   end

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:   if (!RX_IN) state_next = DATA;
         DATA:   if (bit_cnt_reg == LAST_BIT) state_next = par_en_reg ? PARITY : STOP;
         PARITY: state_next = STOP;
         STOP:   state_next = RX_IN ? IDLE : BREAK;
         // A held-low line stays here so it is never mistaken for a start bit
         BREAK:  if (RX_IN) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         par_en_reg     <= 1'b0;
         par_typ_reg    <= 1'b0;
         par_bit_reg    <= 1'b0;
         p_data_reg     <= '0;
         data_valid_reg <= 1'b0;
         par_err_reg    <= 1'b0;
         stop_err_reg   <= 1'b0;
      end else begin
         data_valid_reg <= 1'b0;
         par_err_reg    <= 1'b0;
         stop_err_reg   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (!RX_IN) begin
                  bit_cnt_reg <= '0;
                  par_en_reg  <= PAR_EN;
                  par_typ_reg <= PAR_TYP;
                  par_bit_reg <= 1'b0;
               end
            end
            DATA: begin
               shift_reg[bit_cnt_reg] <= RX_IN;
               bit_cnt_reg            <= bit_cnt_reg + CNT_W'(1);
            end
            PARITY: par_bit_reg <= RX_IN;
            STOP: begin
               // Publish the frame whether or not it carries errors
               data_valid_reg <= 1'b1;
               p_data_reg     <= shift_reg;
               par_err_reg    <= par_err_next;
               stop_err_reg   <= stop_err_next;
            end
            default: ;
         endcase
      end
   end

   assign P_DATA     = p_data_reg;
   assign DATA_VALID = data_valid_reg;
   assign PAR_ERR    = par_err_reg;
   assign STOP_ERR   = stop_err_reg;
   assign Busy       = (state_reg != IDLE);

`ifdef UART_RX_ERR_CNT_EN
   logic [7:0] err_cnt_reg;

   // Updated at the stop sample so the new count appears alongside DATA_VALID
   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_reg <= 8'd0;
      end else if ((state_reg == STOP) && (par_err_next || stop_err_next) &&
                   (err_cnt_reg != 8'hFF)) begin
         err_cnt_reg <= err_cnt_reg + 8'd1;
      end
   end

   assign ERR_CNT = err_cnt_reg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

   localparam int DW = 8;

   logic          clk;
   logic          reset;
   logic          rx_in;
   logic          par_en;
   logic          par_typ;
   logic [DW-1:0] p_data;
   logic          data_valid;
   logic          par_err;
   logic          stop_err;
   logic          busy;
`ifdef UART_RX_ERR_CNT_EN
   logic [7:0]    err_cnt;
`endif

   uart_rx #(.DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .RX_IN      (rx_in),
      .PAR_EN     (par_en),
      .PAR_TYP    (par_typ),
      .P_DATA     (p_data),
      .DATA_VALID (data_valid),
      .PAR_ERR    (par_err),
      .STOP_ERR   (stop_err),
      .Busy       (busy)
`ifdef UART_RX_ERR_CNT_EN
      ,
      .ERR_CNT    (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          perr;
      logic          serr;
      int            start_cyc;
      int            lat;
      logic [7:0]    ecnt;
   } exp_t;

   exp_t          sb_q[$];
   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   int            err_model = 0;
   logic [DW-1:0] hold_data = '0;
   int            prev_valid_cyc = -1;
   int            last_valid_cyc = -1;

   always @(posedge clk) cyc = cyc + 1;

   // Monitor: compares every DATA_VALID pulse against the scoreboard head
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         hold_data = '0;
      end else if (data_valid === 1'b1) begin
         prev_valid_cyc = last_valid_cyc;
         last_valid_cyc = cyc;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_frame: got DATA_VALID with P_DATA=%h, required no frame", p_data);
         end else begin
            e = sb_q.pop_front();
            hold_data = e.data;
            $display("frame data=%h par_err=%b stop_err=%b cycle=%0d", p_data, par_err, stop_err, cyc);
            if (p_data !== e.data) begin
               errors++;
               $display("FAIL p_data: got %h, required %h", p_data, e.data);
            end
            checks++;
            if (par_err !== e.perr) begin
               errors++;
               $display("FAIL par_err: got %b, required %b", par_err, e.perr);
            end
            checks++;
            if (stop_err !== e.serr) begin
               errors++;
               $display("FAIL stop_err: got %b, required %b", stop_err, e.serr);
            end
            checks++;
            // The edge after this negedge is the one that samples DATA_VALID high
            if ((cyc + 1 - e.start_cyc) !== e.lat) begin
               errors++;
               $display("FAIL latency: got %0d, required %0d", cyc + 1 - e.start_cyc, e.lat);
            end
`ifdef UART_RX_ERR_CNT_EN
            checks++;
            if (err_cnt !== e.ecnt) begin
               errors++;
               $display("FAIL err_cnt: got %0d, required %0d", err_cnt, e.ecnt);
            end
`endif
         end
      end else begin
         checks++;
         if ((par_err !== 1'b0) || (stop_err !== 1'b0) || (data_valid !== 1'b0)) begin
            errors++;
            $display("FAIL idle_flags: got valid=%b par_err=%b stop_err=%b, required 0 0 0",
                     data_valid, par_err, stop_err);
         end
         checks++;
         if (p_data !== hold_data) begin
            errors++;
            $display("FAIL p_data_hold: got %h, required %h", p_data, hold_data);
         end
      end
   end

   task automatic drive_bit(input logic b);
      rx_in = b;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_bit(1'b1);
   endtask

   // Sends one frame; must be called at a negedge. flip_par corrupts the parity
   // bit, scramble changes PAR_EN/PAR_TYP after the start bit has been taken.
   task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                             input logic flip_par, input logic stop_b, input logic scramble);
      exp_t e;
      logic par_bit;
      par_bit     = (pt ? (^d) : (~^d)) ^ flip_par;
      e.data      = d;
      e.perr      = pe & flip_par;
      e.serr      = ~stop_b;
      e.start_cyc = cyc + 1;
      e.lat       = pe ? DW + 3 : DW + 2;
      if (e.perr || e.serr) err_model = (err_model < 255) ? err_model + 1 : 255;
      e.ecnt      = 8'(err_model);
      sb_q.push_back(e);
      par_en  = pe;
      par_typ = pt;
      drive_bit(1'b0);
      if (scramble) begin
         par_en  = 1'($urandom);
         par_typ = 1'($urandom);
      end
      for (int i = 0; i < DW; i++) drive_bit(d[i]);
      if (pe) drive_bit(par_bit);
      drive_bit(stop_b);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rx_in = 1'b1;
      par_en = 1'b0;
      par_typ = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({p_data, data_valid, par_err, stop_err, busy} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got p_data=%h valid=%b perr=%b serr=%b busy=%b, required all 0",
                  p_data, data_valid, par_err, stop_err, busy);
      end
`ifdef UART_RX_ERR_CNT_EN
      checks++;
      if (err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt);
      end
`endif
      reset = 1'b0;
      err_model = 0;
      idle(2);
   endtask

   task automatic test_parity_ok();
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);
   endtask

   task automatic test_parity_err();
      // Even parity of 0x01 is 1; sending 0 must flag an error
      send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(3);
   endtask

   task automatic test_stop_break();
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL break_busy: got %b, required 1 (low cycle %0d)", busy, i);
         end
         drive_bit(1'b0);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL break_busy_end: got %b, required 1", busy);
      end
      drive_bit(1'b1);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL break_exit: got busy=%b, required 0", busy);
      end
      idle(3);
   endtask

   task automatic test_back_to_back();
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);
      checks++;
      if ((last_valid_cyc - prev_valid_cyc) !== DW + 2) begin
         errors++;
         $display("FAIL b2b_spacing: got %0d, required %0d", last_valid_cyc - prev_valid_cyc, DW + 2);
      end
   endtask

   task automatic test_reset_mid_frame();
      par_en = 1'b0;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      reset = 1'b1;
      drive_bit(1'b1);
      checks++;
      if ({p_data, data_valid, par_err, stop_err, busy} !== '0) begin
         errors++;
         $display("FAIL mid_reset: got p_data=%h valid=%b perr=%b serr=%b busy=%b, required all 0",
                  p_data, data_valid, par_err, stop_err, busy);
      end
      reset = 1'b0;
      err_model = 0;
      idle(DW + 4);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1);
         idle($urandom_range(0, 2));
      end
      idle(3);
   endtask

   initial begin
      test_reset();
      test_parity_ok();
      test_parity_err();
      test_stop_break();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL missing_frames: got %0d frames outstanding, required 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port RX_IN  input  1  serial line, one bit per clk; idles high.
REQ-005 SHALL have port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-006 SHALL have port PAR_TYP  input  1  0 = odd parity (bit = XNOR-reduce of data), 1 = even parity (bit = XOR-reduce of data).
REQ-007 SHALL have port P_DATA  output  DATA_WIDTH  received data word.
REQ-008 SHALL have port DATA_VALID  output  1  one-cycle pulse; frame complete.
REQ-009 SHALL have port PAR_ERR  output  1  parity mismatch; qualified by DATA_VALID.
REQ-010 SHALL have port STOP_ERR  output  1  stop bit sampled low; qualified by DATA_VALID.
REQ-011 SHALL have port Busy  output  1  high while a frame is being received.

Function
REQ-012 SHALL implement states IDLE, DATA, PARITY, STOP, BREAK.
REQ-013 IDLE: RX_IN sampled 0 SHALL count as the start bit: next state DATA, bit counter cleared, PAR_EN/PAR_TYP latched for the whole frame.
REQ-014 DATA: SHALL sample RX_IN each cycle into data bit [counter], LSB first; after bit DATA_WIDTH-1, next state PARITY if latched PAR_EN = 1, else STOP.
REQ-015 PARITY: SHALL sample RX_IN and compare it with the expected parity for the latched PAR_TYP; next state STOP.
REQ-016 STOP: SHALL sample RX_IN; if 1, next state IDLE; if 0, next state BREAK and STOP_ERR = 1.
REQ-017 BREAK: SHALL hold until RX_IN is sampled 1, then go to IDLE; low cycles in BREAK SHALL NOT start a frame.
REQ-018 In the cycle after the stop sample, SHALL drive DATA_VALID = 1 for exactly one cycle, with P_DATA, PAR_ERR and STOP_ERR valid in that cycle; this applies to error frames too.
REQ-019 PAR_ERR and STOP_ERR SHALL be 0 whenever DATA_VALID = 0; P_DATA SHALL hold its last value until the next DATA_VALID.
REQ-020 PAR_ERR SHALL be 0 for frames received with PAR_EN = 0.
REQ-021 Latency from start-bit sample to DATA_VALID SHALL be DATA_WIDTH+3 cycles with parity, DATA_WIDTH+2 cycles without.
REQ-022 Busy SHALL be 1 in DATA, PARITY, STOP and BREAK, and 0 in IDLE.
REQ-023 A start bit sampled in IDLE in the same cycle as a DATA_VALID pulse SHALL be accepted, so back-to-back frames need no gap beyond the stop bit.
REQ-024 PAR_EN/PAR_TYP changes mid-frame SHALL have no effect until the next start bit.

Reset
REQ-025 While reset = 1 at a clk edge: SHALL set state IDLE, counter 0, P_DATA 0, DATA_VALID 0, PAR_ERR 0, STOP_ERR 0, Busy 0.
REQ-026 Reset mid-frame SHALL abandon the frame with no DATA_VALID pulse.
REQ-027 Reception SHALL resume with the first start bit sampled after reset deasserts.

Configuration
REQ-028 With UART_RX_ERR_CNT_EN defined: SHALL add output ERR_CNT (8 bits), a count of frames with PAR_ERR or STOP_ERR that saturates at 255, is cleared by reset and updates in the DATA_VALID cycle.
REQ-029 Without UART_RX_ERR_CNT_EN: SHALL have no ERR_CNT port and no counter logic.

Structure
REQ-030 Package uart_rx_pkg SHALL hold the state enum, PAR_ODD = 0 / PAR_EVEN = 1 constants and the DATA_WIDTH default.
REQ-031 SHALL instantiate one sub-module, uart_rx_par_chk, which is combinational: inputs data word, PAR_TYP and received bit; output mismatch.

Verification
REQ-032 Test: PAR_EN = 1, PAR_TYP = 0, frame 0,1,0,1,0,0,1,0,1,1,1 (0xA5, parity 1) -> P_DATA = 0xA5, DATA_VALID 11 cycles after the start sample, PAR_ERR = 0, STOP_ERR = 0.
REQ-033 Test: PAR_EN = 1, PAR_TYP = 1, data 0x01, parity bit 0 -> DATA_VALID with P_DATA = 0x01, PAR_ERR = 1 (ERR_CNT = 1 when enabled).
REQ-034 Test: PAR_EN = 0, data 0x3C, stop bit 0, line held low 3 more cycles -> STOP_ERR = 1, Busy stays 1 until the line goes high, no spurious frame.
REQ-035 Test: PAR_EN = 0, frames 0x3C then 0xC3 with zero idle cycles between them -> two DATA_VALID pulses 10 cycles apart, data correct.
REQ-036 Test: reset asserted during data bit 4 of 0xFF -> next cycle all outputs 0, no DATA_VALID; a following frame 0x5A is received correctly.
